// File: rtl/ct_lsu_pfu_pfb_pe_arb_if.sv
// Downstream request bus from the PFB arbiter slot to the prefetch engine.
// The arbiter owns the payload and valid; the engine owns ready.
interface ct_lsu_pfu_pfb_pe_arb_if #(
  parameter int ENTRY_NUM = 8,
  parameter int VA_WIDTH  = 40
);
  logic                 pe_req_vld;
  logic [VA_WIDTH-1:0]  pe_req_va;
  logic [1:0]           pe_req_src;
  logic [1:0]           pe_req_priv_mode;
  logic [ENTRY_NUM-1:0] pe_req_ptr;
  logic                 pe_req_rdy;

  modport master (
    output pe_req_vld, pe_req_va, pe_req_src, pe_req_priv_mode, pe_req_ptr,
    input  pe_req_rdy
  );

  modport slave (
    input  pe_req_vld, pe_req_va, pe_req_src, pe_req_priv_mode, pe_req_ptr,
    output pe_req_rdy
  );
endinterface

// File: rtl/ct_lsu_pfu_pfb_pe_arb.sv
// Round-robin arbiter over PFB entry prefetch-engine requests feeding a
// single-slot holding register with a valid/ready handshake downstream.
module ct_lsu_pfu_pfb_pe_arb #(
  parameter int ENTRY_NUM = 8,
  parameter int VA_WIDTH  = 40
) (
  input  logic                          entry_clk,
  input  logic                          cpurst_b,
  input  logic [ENTRY_NUM-1:0]          entry_pe_req,
  input  logic [2*ENTRY_NUM-1:0]        entry_pe_req_src,
  input  logic [VA_WIDTH*ENTRY_NUM-1:0] entry_inst_new_va,
  input  logic [2*ENTRY_NUM-1:0]        entry_priv_mode,
  input  logic [ENTRY_NUM-1:0]          entry_pop_vld,
  input  logic                          pfu_flush,
  output logic [ENTRY_NUM-1:0]          entry_pe_req_grnt,
  output logic                          arb_idle,
  ct_lsu_pfu_pfb_pe_arb_if.master       pe
);
  localparam int PW = $clog2(ENTRY_NUM);

  logic [ENTRY_NUM-1:0] elig;
  logic [PW-1:0]        rr_q, rr_d, win;
  logic                 slot_free, capture;
  logic                 vld_q, vld_d;
  logic [VA_WIDTH-1:0]  va_q, va_d;
  logic [1:0]           src_q, src_d, priv_q, priv_d;
  logic [ENTRY_NUM-1:0] ptr_q, ptr_d;

  assign elig      = entry_pe_req & ~entry_pop_vld;
  assign slot_free = ~vld_q | pe.pe_req_rdy;
  assign capture   = slot_free & (|elig) & ~pfu_flush;

  // Scan downward so the eligible entry closest above rr_q is written last.
  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= ENTRY_NUM) idx = idx - ENTRY_NUM;
      if (elig[idx[PW-1:0]]) win = idx[PW-1:0];
    end
  end

  assign entry_pe_req_grnt = capture ? (ENTRY_NUM'(1) << win) : '0;
  assign arb_idle          = ~vld_q & ~(|elig);

  always_comb begin
    rr_d = rr_q;
    if (capture) rr_d = (win == PW'(ENTRY_NUM - 1)) ? '0 : win + 1'b1;
  end

  // A popped owner only invalidates the slot; the payload is left in place.
  always_comb begin
    vld_d  = vld_q;
    va_d   = va_q;
    src_d  = src_q;
    priv_d = priv_q;
    ptr_d  = ptr_q;
    if (pfu_flush) begin
      vld_d = 1'b0;
    end else if (capture) begin
      vld_d  = 1'b1;
      va_d   = entry_inst_new_va[int'(win)*VA_WIDTH +: VA_WIDTH];
      src_d  = entry_pe_req_src[int'(win)*2 +: 2];
      priv_d = entry_priv_mode[int'(win)*2 +: 2];
      ptr_d  = ENTRY_NUM'(1) << win;
    end else if (vld_q & pe.pe_req_rdy) begin
      vld_d = 1'b0;
    end else if (vld_q & (|(entry_pop_vld & ptr_q))) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_q   <= '0;
      vld_q  <= 1'b0;
      va_q   <= '0;
      src_q  <= '0;
      priv_q <= '0;
      ptr_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      vld_q  <= vld_d;
      va_q   <= va_d;
      src_q  <= src_d;
      priv_q <= priv_d;
      ptr_q  <= ptr_d;
    end
  end

  assign pe.pe_req_vld       = vld_q;
  assign pe.pe_req_va        = va_q;
  assign pe.pe_req_src       = src_q;
  assign pe.pe_req_priv_mode = priv_q;
  assign pe.pe_req_ptr       = ptr_q;

  a_payload_stable: assert property (@(posedge entry_clk) disable iff (!cpurst_b)
    (vld_q && !pe.pe_req_rdy) |=> ($stable(va_q) && $stable(src_q) && $stable(priv_q) && $stable(ptr_q)));

  a_grnt_legal: assert property (@(posedge entry_clk) disable iff (!cpurst_b)
    ((entry_pe_req_grnt & ~elig) == '0) && $onehot0(entry_pe_req_grnt));
endmodule
